icache_ctrl: RTL
================

ICACHE_CTRL -- requirements
Module: icache_ctrl

Interface
REQ-001 The module SHALL have parameter LINES, default 16, meaning number of direct-mapped cache lines (power of two, 4..64).
REQ-002 The module SHALL have port clk  input  1  system clock, all state updates on rising edge.
REQ-003 The module SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The module SHALL have port fetch_en  input  1  fetch stage requests the instruction at pc this cycle.
REQ-005 The module SHALL have port pc  input  16  word address of the requested instruction.
REQ-006 The module SHALL have port flush  input  1  invalidate all lines.
REQ-007 The module SHALL have port instr  output  16  fetched instruction word.
REQ-008 The module SHALL have port instr_valid  output  1  instr is valid for pc this cycle.
REQ-009 The module SHALL have port stall  output  1  fetch must hold pc; a miss is in progress.
REQ-010 The module SHALL have port mem_req  output  mem_req_type  line-fill request to the unified memory in the MEM unit.
REQ-011 The module SHALL have port mem_data_res  input  mem_data_type  fill data and ready from the unified memory.

Function
REQ-012 Address split SHALL be: word offset pc[1:0], index pc[log2(LINES)+1:2], tag the remaining upper pc bits; line = 4 x 16-bit words = 64 bits, word 0 in data[15:0].
REQ-013 FSM states SHALL be IDLE and FILL only.
REQ-014 In IDLE, hit (fetch_en & valid[index] & tag match) SHALL drive instr_valid=1, stall=0, instr = selected word, combinationally in the same cycle.
REQ-015 In IDLE, miss (fetch_en & !hit) SHALL drive stall=1, instr_valid=0, latch line address pc[15:2], and enter FILL next cycle.
REQ-016 In FILL, mem_req SHALL hold rw=0, addr={2'b00, latched pc[15:2]}, data=0 every cycle until mem_data_res.ready=1; stall=1, instr_valid=0.
REQ-017 Outside FILL, mem_req SHALL drive rw=1 (read disabled), addr=0, data=0.
REQ-018 On the cycle ready=1 in FILL, the line data, tag and valid=1 SHALL be written at the latched index and FSM SHALL return to IDLE; the retried fetch hits the next cycle.
REQ-019 Fill latency SHALL be unbounded; the module SHALL wait for ready without timeout (nominal 4 cycles).
REQ-020 Changes of pc or fetch_en while in FILL SHALL be ignored.
REQ-021 fetch_en=0 in IDLE SHALL drive instr_valid=0, stall=0, no FSM transition.
REQ-022 flush in IDLE SHALL clear all valid bits next edge and force instr_valid=0 that cycle.
REQ-023 flush in FILL SHALL clear all valid bits; the in-flight fill completes and writes its line with valid=0.
REQ-024 flush and ready in the same cycle SHALL leave the filled line invalid.

Reset
REQ-025 rst SHALL clear all valid bits, set FSM to IDLE, drive instr=0, instr_valid=0, stall=0, mem_req.rw=1; data/tag arrays SHALL NOT require reset.
REQ-026 rst asserted during FILL SHALL abandon the fill; any later ready pulse while in IDLE SHALL be ignored.

Configuration
REQ-027 With ICACHE_STATS_EN defined, outputs hit_count[15:0] and miss_count[15:0] SHALL exist, incrementing once per IDLE hit / IDLE miss, saturating at 0xFFFF, cleared by rst.
REQ-028 Without ICACHE_STATS_EN, those ports and counters SHALL be absent and behaviour otherwise identical.

Structure
REQ-029 mem_req_type (addr[15:0], data[63:0], rw) and mem_data_type (data[63:0], ready) and the state enum SHALL live in package icache_def.
REQ-030 Tag/valid/data storage SHALL be one sub-module icache_array (index read port, single write port, valid clear-all).

Verification
REQ-031 After rst, fetch pc=0x0040 -> stall=1, FILL with mem_req.addr=0x0010 rw=0; ready after 4 cycles with data 0x4444_3333_2222_1111 -> next cycle instr=0x1111, instr_valid=1.
REQ-032 Then pc=0x0043 -> same-cycle hit, instr=0x4444, no mem_req (rw=1).
REQ-033 pc=0x0080 (same index, LINES=16, different tag) -> miss, refill evicts; later pc=0x0040 misses again.
REQ-034 flush asserted in FILL, ready same cycle -> return to IDLE, refetch of same pc misses again.
REQ-035 rst on 2nd FILL cycle, ready pulse 2 cycles later -> FSM IDLE, rw=1, no line valid, pc fetch misses.
REQ-036 With ICACHE_STATS_EN: 3 misses, 5 hits -> miss_count=3, hit_count=5; 70000 hits -> hit_count=0xFFFF.

Source files
------------

// File: rtl/icache_ctrl_pkg.sv
// Shared types for the instruction cache: memory bus structs, FSM state and line helpers.
// Imported by icache_ctrl_if, icache_array and icache_ctrl.
package icache_def;

  localparam int WORD_W = 16;
  localparam int LINE_W = 64;

  typedef struct packed {
    logic [15:0] addr;
    logic [63:0] data;
    logic        rw;
  } mem_req_type;

  typedef struct packed {
    logic [63:0] data;
    logic        ready;
  } mem_data_type;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } icache_state_t;

  // rw=1 is the "no read" encoding on the unified memory port.
  localparam mem_req_type MEM_REQ_IDLE = '{addr: 16'h0000, data: 64'h0, rw: 1'b1};

  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                  input logic [1:0] off);
    return line[{off, 4'b0000} +: WORD_W];
  endfunction

endpackage

// File: rtl/icache_ctrl_if.sv
// Line-fill bus between the instruction cache (master) and the unified memory (slave).
interface icache_ctrl_if;
  import icache_def::*;

  // Handshake: while a fill is pending the master holds mem_req with rw=0 and a stable
  // line address; the slave answers with ready=1 for one cycle carrying the whole line on
  // data, and that cycle completes the transfer. rw=1 means no request is outstanding.
  mem_req_type  mem_req;
  mem_data_type mem_data_res;

  modport master (output mem_req, input mem_data_res);
  modport slave  (input mem_req, output mem_data_res);

endinterface

// File: rtl/icache_ctrl_array.sv
// Tag/valid/data storage for the direct-mapped cache: one read port, one write port,
// and a single-cycle clear of every valid bit. Only the valid bits are reset.
module icache_array
  import icache_def::*;
#(
  parameter int LINES = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [$clog2(LINES)-1:0]      rd_index,
  output logic                          rd_valid,
  output logic [13-$clog2(LINES):0]     rd_tag,
  output logic [LINE_W-1:0]             rd_data,
  input  logic                          we,
  input  logic [$clog2(LINES)-1:0]      wr_index,
  input  logic [13-$clog2(LINES):0]     wr_tag,
  input  logic [LINE_W-1:0]             wr_data,
  input  logic                          wr_valid,
  input  logic                          clear_all
);

  localparam int IDXW = $clog2(LINES);
  localparam int TAGW = 14 - IDXW;

  logic [LINES-1:0]  valid_q;
  logic [TAGW-1:0]   tag_q  [LINES];
  logic [LINE_W-1:0] data_q [LINES];

  // A write in the same cycle as clear_all lands after the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      if (clear_all) valid_q <= '0;
      if (we) valid_q[wr_index] <= wr_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller: same-cycle hits, blocking line fills.
// Optional hit/miss statistics ports are built when ICACHE_STATS_EN is defined.
module icache_ctrl
  import icache_def::*;
#(
  parameter int LINES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fetch_en,
  input  logic [15:0]          pc,
  input  logic                 flush,
  output logic [15:0]          instr,
  output logic                 instr_valid,
  output logic                 stall,
  output icache_state_t        fsm_state,
`ifdef ICACHE_STATS_EN
  output logic [15:0]          hit_count,
  output logic [15:0]          miss_count,
`endif
  icache_ctrl_if.master        mem
);

  localparam int IDXW = $clog2(LINES);
  localparam int TAGW = 14 - IDXW;

  icache_state_t     state, state_next;
  logic [13:0]       line_addr;
  logic              fill_flushed;
  logic              rd_valid;
  logic [TAGW-1:0]   rd_tag;
  logic [LINE_W-1:0] rd_data;
  logic              hit;
  logic              we;
  logic              wr_valid;

  assign hit = (state == IDLE) && fetch_en && rd_valid && (rd_tag == pc[15:IDXW+2]);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    instr_valid = 1'b0;
    stall       = 1'b0;
    we          = 1'b0;
    mem.mem_req = MEM_REQ_IDLE;
    case (state)
      IDLE: begin
        if (fetch_en) begin
          if (hit) begin
            instr_valid = !flush;
          end else begin
            stall      = 1'b1;
            state_next = FILL;
          end
        end
      end
      FILL: begin
        stall            = 1'b1;
        mem.mem_req.rw   = 1'b0;
        mem.mem_req.addr = {2'b00, line_addr};
        if (mem.mem_data_res.ready) begin
          we         = 1'b1;
          state_next = IDLE;
        end
      end
    endcase
    // Reset wins over everything, including an in-flight fill.
    if (rst) begin
      instr_valid = 1'b0;
      stall       = 1'b0;
      we          = 1'b0;
      mem.mem_req = MEM_REQ_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && fetch_en && !hit) line_addr <= pc[15:2];
  end

  // A flush seen at any point of a fill makes that fill land invalid.
  always_ff @(posedge clk) begin
    if (rst || state == IDLE) fill_flushed <= 1'b0;
    else if (flush)           fill_flushed <= 1'b1;
  end

  assign wr_valid  = !(flush || fill_flushed);
  assign instr     = instr_valid ? line_word(rd_data, pc[1:0]) : 16'h0000;
  assign fsm_state = state;

  icache_array #(.LINES(LINES)) u_array (
    .clk       (clk),
    .rst       (rst),
    .rd_index  (pc[IDXW+1:2]),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .we        (we),
    .wr_index  (line_addr[IDXW-1:0]),
    .wr_tag    (line_addr[13:IDXW]),
    .wr_data   (mem.mem_data_res.data),
    .wr_valid  (wr_valid),
    .clear_all (flush)
  );

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == IDLE) begin
      if (instr_valid && hit_count != 16'hFFFF)  hit_count  <= hit_count + 16'd1;
      if (stall && miss_count != 16'hFFFF)       miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule
